// File: rtl/aip_nb_gain_slave_pkg.sv
// Shared definitions for the narrow-band gain slave.
// Holds the AIP config codes, STATUS bit positions, FSM states, saturation
// limits and the Q8.8 shift/saturate helper used by the last pipe stage.
package aip_nb_pkg;

  localparam logic [4:0] CFG_MEM_IN  = 5'h00;
  localparam logic [4:0] CFG_MEM_OUT = 5'h01;
  localparam logic [4:0] CFG_CONFIG  = 5'h02;
  localparam logic [4:0] CFG_STATUS  = 5'h03;
  localparam logic [4:0] CFG_ID      = 5'h1F;

  localparam int ST_DONE   = 0;
  localparam int ST_BUSY   = 1;
  localparam int ST_INT_EN = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic signed [31:0] SAT_MAX = 32'sd32767;
  localparam logic signed [31:0] SAT_MIN = -32'sd32768;

  // Drop the 8 fractional bits of a Q8.8 product (arithmetic shift floors)
  // and clamp to the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [31:0] p);
    logic signed [31:0] r;
    r = p >>> 8;
    if (r > SAT_MAX)      return 16'h7FFF;
    else if (r < SAT_MIN) return 16'h8000;
    else                  return r[15:0];
  endfunction

endpackage

// File: rtl/aip_nb_dp_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr, rdata  read port; rdata updates only when re is high and
//                     holds otherwise, so callers can use it as a held result
module aip_nb_dp_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/aip_nb_gain_slave.sv
// AIP slave: buffers signed 16-bit samples, applies a Q8.8 gain with
// saturation and stores the results for readback.
// Ports:
//   i_clk, i_rst_a       clock, async active-low reset
//   i_dataInAIP          write data from the controller
//   i_configAIP          target select (MEM_IN/MEM_OUT/CONFIG/STATUS/ID)
//   i_readAIP/i_writeAIP one-cycle access strobes
//   i_start              start a processing run
//   o_dataOutAIP         read data, valid 1 cycle after i_readAIP, held
//   o_int                level interrupt, raised at run completion if enabled
module aip_nb_gain_slave
  import aip_nb_pkg::*;
#(
  parameter int          DATA_WORD = 32,
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] IP_ID     = 32'h4E42_0001
) (
  input  logic                 i_clk,
  input  logic                 i_rst_a,
  input  logic [DATA_WORD-1:0] i_dataInAIP,
  input  logic [4:0]           i_configAIP,
  input  logic                 i_readAIP,
  input  logic                 i_writeAIP,
  input  logic                 i_start,
  output logic [DATA_WORD-1:0] o_dataOutAIP,
  output logic                 o_int
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int STAGES = 2;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr, idx, idx_p1, idx_p2, last_idx;
  logic [ADDR_W:0]     len, len_m1;
  logic [15:0]         gain, in_rdata, out_rdata, res;
  logic                done, int_en, drain_cnt, busy, issue;
  logic                wr_mem_in, wr_cfg, wr_stat, rd_mem_out;
  logic [STAGES:1]     vld_pipe;
  logic signed [31:0]  prod;
  logic                sel_ram;
  logic [DATA_WORD-1:0] dout_q;
  logic [2:0]          status;

  assign busy       = (state == RUN) || (state == DRAIN);
  assign issue      = (state == RUN);
  assign wr_mem_in  = i_writeAIP && (i_configAIP == CFG_MEM_IN) && !busy;
  assign wr_cfg     = i_writeAIP && (i_configAIP == CFG_CONFIG) && !busy;
  assign wr_stat    = i_writeAIP && (i_configAIP == CFG_STATUS);
  assign rd_mem_out = i_readAIP  && (i_configAIP == CFG_MEM_OUT) && !busy;

  // LEN of 0 or beyond the buffer means "whole buffer".
  assign len_m1   = len - 1'b1;
  assign last_idx = (len == '0 || len > DEPTH_L) ? '1 : len_m1[ADDR_W-1:0];

  always_comb begin
    status            = '0;
    status[ST_DONE]   = done;
    status[ST_BUSY]   = busy;
    status[ST_INT_EN] = int_en;
  end

  assign res = sat16(prod);

  aip_nb_dp_ram #(.ADDR_W(ADDR_W), .DATA_W(16)) u_in_buf (
    .clk(i_clk), .rst_n(i_rst_a),
    .we(wr_mem_in), .waddr(wr_ptr), .wdata(i_dataInAIP[15:0]),
    .re(issue), .raddr(idx), .rdata(in_rdata)
  );

  aip_nb_dp_ram #(.ADDR_W(ADDR_W), .DATA_W(16)) u_out_buf (
    .clk(i_clk), .rst_n(i_rst_a),
    .we(vld_pipe[STAGES]), .waddr(idx_p2), .wdata(res),
    .re(rd_mem_out), .raddr(rd_ptr), .rdata(out_rdata)
  );

  // MEM_OUT data comes straight from the out_buf read register (already one
  // cycle after the strobe); all other read data is captured in dout_q.
  assign o_dataOutAIP = sel_ram ? {{(DATA_WORD-16){out_rdata[15]}}, out_rdata} : dout_q;

  always_ff @(posedge i_clk or negedge i_rst_a) begin
    if (!i_rst_a) begin
      sel_ram <= 1'b0;
      dout_q  <= '0;
    end else if (i_readAIP) begin
      sel_ram <= 1'b0;
      dout_q  <= '0;
      case (i_configAIP)
        CFG_MEM_OUT: sel_ram <= !busy;
        CFG_STATUS:  dout_q  <= DATA_WORD'(status);
        CFG_ID:      dout_q  <= DATA_WORD'(IP_ID);
        default:     ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_a) begin
    if (!i_rst_a) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      len    <= '0;
      gain   <= 16'h0100;
    end else if (wr_cfg) begin
      gain   <= i_dataInAIP[31:16];
      len    <= i_dataInAIP[ADDR_W:0];
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_mem_in)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_mem_out) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FSM plus STATUS-owned flags. A STATUS write is applied after the state
  // update so a clear in the DONE cycle wins over the completion event.
  always_ff @(posedge i_clk or negedge i_rst_a) begin
    if (!i_rst_a) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= 1'b0;
      done      <= 1'b0;
      o_int     <= 1'b0;
      int_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          state     <= RUN;
          idx       <= '0;
          drain_cnt <= 1'b0;
          done      <= 1'b0;
          o_int     <= 1'b0;
        end
        RUN: begin
          idx <= idx + 1'b1;
          if (idx == last_idx) state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          o_int <= int_en;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (wr_stat) begin
        int_en <= i_dataInAIP[1];
        if (i_dataInAIP[0]) begin
          done  <= 1'b0;
          o_int <= 1'b0;
        end
      end
    end
  end

  // Gain pipe: stage 1 = in_buf read, stage 2 = multiply, stage 3 = write.
  always_ff @(posedge i_clk or negedge i_rst_a) begin
    if (!i_rst_a) begin
      vld_pipe <= '0;
      idx_p1   <= '0;
      idx_p2   <= '0;
      prod     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], issue};
      idx_p1   <= idx;
      idx_p2   <= idx_p1;
      prod     <= $signed(in_rdata) * $signed(gain);
    end
  end

endmodule

// File: tb/tb_aip_nb_gain_slave.sv
// Bench for aip_nb_gain_slave: gain table, hand-written corner sequences and
// randomized runs checked against a sample-level model of the buffers.
module tb_aip_nb_gain_slave;
  import aip_nb_pkg::*;

  localparam int DEPTH = 64;

  logic        i_clk = 1'b0, i_rst_a = 1'b0;
  logic [31:0] i_dataInAIP = '0;
  logic [4:0]  i_configAIP = '0;
  logic        i_readAIP = 1'b0, i_writeAIP = 1'b0, i_start = 1'b0;
  logic [31:0] o_dataOutAIP;
  logic        o_int;

  aip_nb_gain_slave dut (
    .i_clk(i_clk), .i_rst_a(i_rst_a), .i_dataInAIP(i_dataInAIP),
    .i_configAIP(i_configAIP), .i_readAIP(i_readAIP), .i_writeAIP(i_writeAIP),
    .i_start(i_start), .o_dataOutAIP(o_dataOutAIP), .o_int(o_int)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  // model state
  logic [15:0] m_in [DEPTH];
  logic [15:0] m_out[DEPTH];
  bit          m_in_v [DEPTH];
  bit          m_out_v[DEPTH];
  int          m_wr, m_rd, m_len, t0, exp_lat;
  logic [15:0] m_gain;
  bit          m_int_en, m_done, m_busy, m_int;

  typedef struct {
    logic [15:0] gain;
    logic [15:0] sample;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] gain_ref(input logic [15:0] s, input logic [15:0] g);
    int p, r;
    p = int'($signed(s)) * int'($signed(g));
    if (p >= 0) r = p / 256;
    else        r = -((-p + 255) / 256);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic int eff_len();
    return (m_len == 0 || m_len > DEPTH) ? DEPTH : m_len;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_len = 0; m_gain = 16'h0100;
    m_int_en = 0; m_done = 0; m_busy = 0; m_int = 0;
    for (int i = 0; i < DEPTH; i++) begin m_in_v[i] = 0; m_out_v[i] = 0; end
  endtask

  task automatic op_write(input logic [4:0] cfg, input logic [31:0] d);
    @(posedge i_clk); #1;
    i_configAIP = cfg; i_dataInAIP = d; i_writeAIP = 1'b1;
    @(posedge i_clk); #1;
    i_writeAIP = 1'b0;
    case (cfg)
      CFG_MEM_IN: if (!m_busy) begin
        m_in[m_wr] = d[15:0]; m_in_v[m_wr] = 1; m_wr = (m_wr + 1) % DEPTH;
      end
      CFG_CONFIG: if (!m_busy) begin
        m_gain = d[31:16]; m_len = int'(d[6:0]); m_wr = 0; m_rd = 0;
      end
      CFG_STATUS: begin
        m_int_en = d[1];
        if (d[0]) begin m_done = 0; m_int = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic op_read(input logic [4:0] cfg, input string name, output logic [31:0] got);
    logic [31:0] exp;
    bit do_chk;
    do_chk = 1;
    case (cfg)
      CFG_MEM_OUT: if (m_busy) exp = '0;
                   else begin
                     do_chk = m_out_v[m_rd];
                     exp = {{16{m_out[m_rd][15]}}, m_out[m_rd]};
                     m_rd = (m_rd + 1) % DEPTH;
                   end
      CFG_STATUS:  exp = {29'b0, m_int_en, m_busy, m_done};
      CFG_ID:      exp = 32'h4E42_0001;
      default:     exp = '0;
    endcase
    @(posedge i_clk); #1;
    i_configAIP = cfg; i_readAIP = 1'b1;
    @(posedge i_clk); #1;
    i_readAIP = 1'b0;
    got = o_dataOutAIP;
    if (do_chk) check(name, got, exp);
  endtask

  task automatic start_pulse();
    @(posedge i_clk); #1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    if (!m_busy) begin
      for (int i = 0; i < eff_len(); i++) begin
        m_out[i] = gain_ref(m_in[i], m_gain);
        m_out_v[i] = m_in_v[i];
      end
      exp_lat = eff_len() + 3;
      t0 = cyc;
      m_busy = 1; m_done = 0; m_int = 0;
    end
  endtask

  task automatic wait_done(input string name);
    int lat;
    lat = -1;
    if (m_int_en) begin
      for (int k = 0; k < 300; k++) begin
        @(posedge i_clk); #1;
        if (o_int) begin lat = cyc - t0; break; end
      end
      check(name, lat, exp_lat);
    end else begin
      repeat (exp_lat + 3) @(posedge i_clk);
      #1;
      check(name, {31'b0, o_int}, 32'h0);
    end
    m_busy = 0; m_done = 1; m_int = m_int_en;
  endtask

  logic [31:0] rd;

  initial begin
    vt[0] = '{16'h0100, 16'h0001, 32'h0000_0001};
    vt[1] = '{16'h0100, 16'hFFFE, 32'hFFFF_FFFE};
    vt[2] = '{16'h0100, 16'd300,  32'd300};
    vt[3] = '{16'h0100, 16'h8000, 32'hFFFF_8000};
    vt[4] = '{16'h0200, 16'd20000, 32'h0000_7FFF};
    vt[5] = '{16'h0200, 16'hB1E0, 32'hFFFF_8000};
    vt[6] = '{16'hFF80, 16'd101,  32'hFFFF_FFCD};
    vt[7] = '{16'h0080, 16'd3,    32'h0000_0001};
    vt[8] = '{16'h0080, 16'hFFFD, 32'hFFFF_FFFE};
    vt[9] = '{16'hFF00, 16'h8000, 32'h0000_7FFF};
    model_reset();

    // reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_dout", o_dataOutAIP, 32'h0);
    check("rst_int", {31'b0, o_int}, 32'h0);
    i_rst_a = 1'b1;
    op_read(CFG_ID, "id", rd);
    op_read(CFG_STATUS, "rst_status", rd);

    // unity gain, latency and interrupt
    op_write(CFG_CONFIG, 32'h0100_0004);
    op_write(CFG_MEM_IN, 32'h0000_0001);
    op_write(CFG_MEM_IN, 32'h0000_FFFE);
    op_write(CFG_MEM_IN, 32'd300);
    op_write(CFG_MEM_IN, 32'h0000_8000);
    op_write(CFG_STATUS, 32'h2);
    start_pulse();
    wait_done("unity_lat");
    for (int i = 0; i < 4; i++) op_read(CFG_MEM_OUT, "unity_out", rd);
    op_read(CFG_STATUS, "status_done", rd);
    op_write(CFG_STATUS, 32'h1);
    check("int_clear", {31'b0, o_int}, {31'b0, m_int});

    // same kind of run with interrupt disabled
    op_write(CFG_CONFIG, 32'h0100_0001);
    op_write(CFG_MEM_IN, 32'd7);
    start_pulse();
    wait_done("noint_level");
    op_read(CFG_STATUS, "noint_status", rd);
    op_write(CFG_STATUS, 32'h3);

    // gain table
    for (int i = 0; i < 10; i++) begin
      op_write(CFG_CONFIG, {vt[i].gain, 16'h0001});
      op_write(CFG_MEM_IN, {16'h0, vt[i].sample});
      start_pulse();
      wait_done("tbl_lat");
      op_read(CFG_MEM_OUT, "tbl_model", rd);
      check($sformatf("tbl_%0d", i), rd, vt[i].exp);
      op_write(CFG_STATUS, 32'h3);
    end

    // busy behaviour
    op_write(CFG_CONFIG, 32'h0100_0009);
    for (int i = 0; i < 8; i++) op_write(CFG_MEM_IN, i * 100);
    start_pulse();
    start_pulse();
    op_write(CFG_MEM_IN, 32'h0000_1234);
    op_read(CFG_MEM_OUT, "busy_memout", rd);
    op_read(CFG_STATUS, "busy_status", rd);
    wait_done("busy_lat");
    op_write(CFG_STATUS, 32'h3);
    repeat (20) @(posedge i_clk);
    #1;
    check("done_once", {31'b0, o_int}, 32'h0);
    op_write(CFG_MEM_IN, 32'h0000_0042);
    start_pulse();
    wait_done("rerun_lat");
    for (int i = 0; i < 9; i++) op_read(CFG_MEM_OUT, "rerun_out", rd);
    check("wrptr_held", rd, 32'h0000_0042);
    op_write(CFG_STATUS, 32'h3);

    // DEPTH+1 writes wrap onto entry 0
    op_write(CFG_CONFIG, 32'h0100_0001);
    for (int i = 0; i <= DEPTH; i++) op_write(CFG_MEM_IN, 1000 + i);
    start_pulse();
    wait_done("wrap_lat");
    op_read(CFG_MEM_OUT, "wrap_model", rd);
    check("wrap_entry0", rd, 32'd1064);
    op_write(CFG_STATUS, 32'h3);

    // LEN=0 means the whole buffer
    op_write(CFG_CONFIG, 32'h0180_0000);
    for (int i = 0; i < DEPTH; i++) op_write(CFG_MEM_IN, {16'h0, 16'($urandom)});
    start_pulse();
    wait_done("len0_lat");
    for (int i = 0; i < DEPTH; i++) op_read(CFG_MEM_OUT, "len0_out", rd);
    op_write(CFG_STATUS, 32'h3);

    // randomized runs
    for (int it = 0; it < 10; it++) begin
      int nw, nr;
      op_write(CFG_CONFIG, {16'($urandom), 9'h0, 7'($urandom_range(0, 127))});
      op_write(5'h05, $urandom);
      nw = $urandom_range(0, 70);
      for (int i = 0; i < nw; i++) op_write(CFG_MEM_IN, $urandom);
      start_pulse();
      wait_done("rnd_lat");
      nr = $urandom_range(1, eff_len());
      for (int i = 0; i < nr; i++) op_read(CFG_MEM_OUT, "rnd_out", rd);
      op_read(5'h07, "bad_cfg", rd);
      op_read(CFG_STATUS, "rnd_status", rd);
      op_write(CFG_STATUS, 32'h3);
    end

    // reset in the middle of a run
    op_write(CFG_CONFIG, 32'h0100_0000);
    start_pulse();
    repeat (10) @(posedge i_clk);
    #3 i_rst_a = 1'b0;
    #1;
    check("midrun_int", {31'b0, o_int}, 32'h0);
    check("midrun_dout", o_dataOutAIP, 32'h0);
    model_reset();
    repeat (2) @(posedge i_clk);
    #2 i_rst_a = 1'b1;
    op_read(CFG_STATUS, "midrun_status", rd);
    op_read(CFG_ID, "midrun_id", rd);
    repeat (80) @(posedge i_clk);
    op_read(CFG_STATUS, "no_partial_done", rd);
    check("no_partial_int", {31'b0, o_int}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
